hw5_issue_queue: RTL and testbench
==================================

Name: hw5_issue_queue

Overview:
Upstream issue stage for the pipelined ALU (hw5_unit). Buffers operand/op commands from the bench or sequencer through a valid/ready handshake. Issues at most one command per cycle into the ALU input port, and stamps each issued command with a rolling non-zero tag on in_databits. Tag 0 is reserved as the bubble marker, so downstream logic can tell real results from idle cycles by out_databits != 0.

Parameters:
WIDTH, 32, operand width; matches ALU a/b/res
DATABITS, 4, tag width; matches ALU in_databits/out_databits
DEPTH, 8, FIFO entries; power of two, >= 2
ADDRBITS, 3, log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (asserted when 0)
cmd_valid  input  1  producer presents a command
cmd_ready  output  1  queue can accept; high iff not full
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
cmd_op  input  2  ALU opcode
stall  input  1  downstream hold; no issue while high
a  output  WIDTH  to ALU a
b  output  WIDTH  to ALU b
in_op  output  2  to ALU in_op
in_databits  output  DATABITS  to ALU in_databits; 0 = bubble
issue_fire  output  1  high in cycles where a real command is presented to the ALU

Behaviour:
- Everything is sampled on posedge clk. Reset acts only when reset==0 at a clock edge.
- Reset values: all output registers clear, so a=0, b=0, in_op=0, in_databits=0, issue_fire=0. The FIFO is emptied (rd/wr pointers 0, count 0) and cmd_ready=1 after reset. The tag counter is set to 1.
- Reset asserted mid-operation discards all queued entries and any in-flight issue. It is not tied to any other event.
- Enqueue: a command is accepted when cmd_valid && cmd_ready at the edge. It is written at wr_ptr, and wr_ptr increments mod DEPTH.
- cmd_ready is combinational from count: cmd_ready = (count != DEPTH). It does not depend on the same-cycle dequeue, so a full queue refuses input even while draining.
- Issue condition at each edge: if count != 0 and stall == 0, then:
  - the head entry is registered onto a/b/in_op;
  - in_databits <= tag; issue_fire <= 1;
  - rd_ptr increments and the tag advances.
- Otherwise, at that edge:
  - in_databits <= 0 and issue_fire <= 0;
  - a/b/in_op hold their previous values (don't-care for the ALU).
- Latency: a command enqueued at edge N into an empty, unstalled queue appears on the ALU port after edge N+1. This is one cycle of FIFO write plus a registered issue; there is no fall-through.
- Throughput: one issue per cycle sustained. Simultaneous enqueue and dequeue leaves count unchanged.
- Tag arithmetic:
  - tags run 1,2,...,2^DATABITS-1, then wrap to 1; 0 is never issued;
  - with DATABITS=4 the sequence is 1..15,1,...
- stall is sampled at the issue edge. While stall=1 the queue still accepts commands until full.
- count is ADDRBITS+1 bits wide and ranges 0..DEPTH. The pointers wrap mod DEPTH.
- No overflow/underflow is possible. Enqueue is gated by cmd_ready; dequeue is gated by count != 0.

Optional Feature:
HW5_ISSUE_OCCUPANCY_EN. When defined, the block adds an output port `occupancy` [ADDRBITS:0]:
- it is a registered copy of count, updated every edge and reset to 0;
- it lags true count by one cycle.
When not defined, the port and register do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 2 edges with cmd_valid=1 -> in_databits=0, issue_fire=0, cmd_ready=1 after release, and nothing is enqueued during reset.
- Single command: enqueue a=5, b=3, op=2 into an empty queue with stall=0 -> one edge later a=5, b=3, in_op=2, in_databits=1, issue_fire=1. The following cycle in_databits=0.
- Fill: stall=1, then present 9 back-to-back commands with DEPTH=8 -> cmd_ready drops after the 8th accept and the 9th is held. Releasing stall issues 8 entries in order, with tags 1..8.
- Streaming: stall=0, cmd_valid=1 for 20 consecutive cycles with distinct a -> one issue per cycle, in order. Tags run 1..15,1..5 with no 0 tag among valid issues.
- Stall mid-stream: toggle stall=1 for 3 cycles during streaming -> exactly 3 bubbles (in_databits=0), no lost or duplicated command, and the tag resumes with the next value.
- Reset mid-stream: assert reset with 5 entries queued -> the queue empties, the tag restarts at 1, and the first post-reset command issues with in_databits=1.

Source files
------------

// File: rtl/hw5_issue_queue.sv
// hw5_issue_queue: tagged FIFO issue stage for hw5_unit; define HW5_ISSUE_OCCUPANCY_EN to add the occupancy output
module hw5_issue_queue #(
    parameter int WIDTH    = 32,
    parameter int DATABITS = 4,
    parameter int DEPTH    = 8,
    parameter int ADDRBITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [WIDTH-1:0]    cmd_a,
    input  logic [WIDTH-1:0]    cmd_b,
    input  logic [1:0]          cmd_op,
    input  logic                stall,
    output logic [WIDTH-1:0]    a,
    output logic [WIDTH-1:0]    b,
    output logic [1:0]          in_op,
    output logic [DATABITS-1:0] in_databits,
    output logic                issue_fire
`ifdef HW5_ISSUE_OCCUPANCY_EN
    ,
    output logic [ADDRBITS:0]   occupancy
`endif
);
    logic [WIDTH-1:0]    mem_a  [DEPTH];
    logic [WIDTH-1:0]    mem_b  [DEPTH];
    logic [1:0]          mem_op [DEPTH];
    logic [ADDRBITS-1:0] wr_ptr, rd_ptr;
    logic [ADDRBITS:0]   count;
    logic [DATABITS-1:0] tag;
    logic                push, pop;

    // handshake and issue decisions; ready ignores same-cycle drain
    always_comb begin
        cmd_ready = count != (ADDRBITS+1)'(DEPTH);
        push      = cmd_valid && cmd_ready;
        pop       = (count != '0) && !stall;
    end

    // entry storage, written only on accepted commands outside reset
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
            mem_op[wr_ptr] <= cmd_op;
        end
    end

    // pointers, count, tag and registered issue port; tag skips 0 so 0 marks a bubble
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tag         <= DATABITS'(1);
            a           <= '0;
            b           <= '0;
            in_op       <= '0;
            in_databits <= '0;
            issue_fire  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDRBITS'(1);
            if (pop) begin
                a           <= mem_a[rd_ptr];
                b           <= mem_b[rd_ptr];
                in_op       <= mem_op[rd_ptr];
                in_databits <= tag;
                issue_fire  <= 1'b1;
                rd_ptr      <= rd_ptr + ADDRBITS'(1);
                tag         <= (tag == '1) ? DATABITS'(1) : tag + DATABITS'(1);
            end else begin
                in_databits <= '0;
                issue_fire  <= 1'b0;
            end
            count <= count + (ADDRBITS+1)'(push) - (ADDRBITS+1)'(pop);
        end
    end

`ifdef HW5_ISSUE_OCCUPANCY_EN
    // occupancy trails count by one edge
    always_ff @(posedge clk) begin
        if (!reset) occupancy <= '0;
        else        occupancy <= count;
    end
`endif
endmodule

// File: tb/tb_hw5_issue_queue.sv
// tb_hw5_issue_queue: directed self-checking bench for hw5_issue_queue
module tb_hw5_issue_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [1:0]  cmd_op = '0;
    logic        stall = 1'b0;
    logic [31:0] a, b;
    logic [1:0]  in_op;
    logic [3:0]  in_databits;
    logic        issue_fire;
`ifdef HW5_ISSUE_OCCUPANCY_EN
    logic [3:0]  occupancy;
`endif
    int errors = 0;
    int checks = 0;

    hw5_issue_queue dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .stall(stall),
        .a(a), .b(b), .in_op(in_op), .in_databits(in_databits), .issue_fire(issue_fire)
`ifdef HW5_ISSUE_OCCUPANCY_EN
        , .occupancy(occupancy)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; cmd_valid = 1'b0; stall = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 1'b1; cmd_a = 32'd99; cmd_b = 32'd98; cmd_op = 2'd3;
        step();
        step();
        checks++; if (in_databits !== 4'd0) begin errors++; $display("FAIL reset_tag got=%0d exp=0", in_databits); end
        checks++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL reset_fire got=%0b exp=0", issue_fire); end
        checks++; if (a !== 32'd0 || b !== 32'd0 || in_op !== 2'd0) begin errors++; $display("FAIL reset_data got a=%0d b=%0d op=%0d exp 0", a, b, in_op); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
        reset = 1'b1; cmd_valid = 1'b0;
        step();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%0b exp=1", cmd_ready); end
        step();
        checks++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL reset_no_enqueue got=%0b exp=0", issue_fire); end
`ifdef HW5_ISSUE_OCCUPANCY_EN
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
`endif
    endtask

    task automatic test_single();
        do_reset();
        cmd_valid = 1'b1; cmd_a = 32'd5; cmd_b = 32'd3; cmd_op = 2'd2;
        step();
        cmd_valid = 1'b0;
        checks++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL single_no_fallthrough got=%0b exp=0", issue_fire); end
        step();
        checks++; if (a !== 32'd5 || b !== 32'd3 || in_op !== 2'd2) begin errors++; $display("FAIL single_data got a=%0d b=%0d op=%0d exp 5 3 2", a, b, in_op); end
        checks++; if (in_databits !== 4'd1 || issue_fire !== 1'b1) begin errors++; $display("FAIL single_tag got tag=%0d fire=%0b exp 1 1", in_databits, issue_fire); end
        step();
        checks++; if (in_databits !== 4'd0 || issue_fire !== 1'b0) begin errors++; $display("FAIL single_bubble got tag=%0d fire=%0b exp 0 0", in_databits, issue_fire); end
        checks++; if (a !== 32'd5) begin errors++; $display("FAIL single_hold got a=%0d exp=5", a); end
    endtask

    task automatic test_fill();
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cmd_valid = 1'b1; cmd_a = 32'(100 + i); cmd_b = 32'(i); cmd_op = 2'(i);
            #1;
            checks++; if (cmd_ready !== (i < 8)) begin errors++; $display("FAIL fill_ready[%0d] got=%0b exp=%0b", i, cmd_ready, i < 8); end
            step();
            checks++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL fill_stall_fire[%0d] got=%0b exp=0", i, issue_fire); end
        end
`ifdef HW5_ISSUE_OCCUPANCY_EN
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL fill_occupancy got=%0d exp=8", occupancy); end
`endif
        cmd_valid = 1'b0; stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (issue_fire !== 1'b1 || a !== 32'(100 + k) || in_databits !== 4'(k + 1))
                begin errors++; $display("FAIL fill_drain[%0d] got fire=%0b a=%0d tag=%0d exp 1 %0d %0d", k, issue_fire, a, in_databits, 100 + k, k + 1); end
        end
        step();
        checks++; if (issue_fire !== 1'b0 || in_databits !== 4'd0) begin errors++; $display("FAIL fill_ninth_dropped got fire=%0b tag=%0d exp 0 0", issue_fire, in_databits); end
    endtask

    task automatic test_streaming();
        int exp_tag = 1;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            cmd_valid = (c < 20); cmd_a = 32'(200 + c); cmd_b = 32'd0; cmd_op = 2'd1;
            step();
            if (c >= 1) begin
                checks++; if (issue_fire !== 1'b1 || a !== 32'(200 + c - 1) || in_databits !== 4'(exp_tag))
                    begin errors++; $display("FAIL stream[%0d] got fire=%0b a=%0d tag=%0d exp 1 %0d %0d", c, issue_fire, a, in_databits, 200 + c - 1, exp_tag); end
                exp_tag = (exp_tag == 15) ? 1 : exp_tag + 1;
            end
        end
        checks++; if (exp_tag !== 6) begin errors++; $display("FAIL stream_count got=%0d exp=6", exp_tag); end
    endtask

    task automatic test_stall_mid();
        int exp_tag = 1;
        int issued = 0;
        int first = -1;
        int last = -1;
        int bubbles = 0;
        bit fired [20];
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cmd_valid = (c < 12); cmd_a = 32'(300 + c); stall = (c >= 4 && c <= 6);
            step();
            fired[c] = issue_fire;
            if (issue_fire === 1'b1) begin
                checks++; if (a !== 32'(300 + issued) || in_databits !== 4'(exp_tag))
                    begin errors++; $display("FAIL stall_issue[%0d] got a=%0d tag=%0d exp %0d %0d", c, a, in_databits, 300 + issued, exp_tag); end
                if (first < 0) first = c;
                last = c;
                issued++;
                exp_tag = (exp_tag == 15) ? 1 : exp_tag + 1;
            end else begin
                checks++; if (in_databits !== 4'd0) begin errors++; $display("FAIL stall_bubble_tag[%0d] got=%0d exp=0", c, in_databits); end
            end
        end
        stall = 1'b0;
        for (int c = 0; c < 20; c++) if (first >= 0 && c > first && c < last && !fired[c]) bubbles++;
        checks++; if (issued !== 12) begin errors++; $display("FAIL stall_issued got=%0d exp=12", issued); end
        checks++; if (bubbles !== 3) begin errors++; $display("FAIL stall_bubbles got=%0d exp=3", bubbles); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            cmd_valid = 1'b1; cmd_a = 32'(400 + i);
            step();
        end
        cmd_valid = 1'b0;
        step();
        checks++; if (in_databits !== 4'd2) begin errors++; $display("FAIL rmid_pre_tag got=%0d exp=2", in_databits); end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_a = 32'(500 + i);
            step();
        end
        cmd_valid = 1'b0; reset = 1'b0;
        step();
        reset = 1'b1; stall = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || issue_fire !== 1'b0) begin errors++; $display("FAIL rmid_cleared got ready=%0b fire=%0b exp 1 0", cmd_ready, issue_fire); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (issue_fire !== 1'b0 || in_databits !== 4'd0) begin errors++; $display("FAIL rmid_empty[%0d] got fire=%0b tag=%0d exp 0 0", i, issue_fire, in_databits); end
        end
        cmd_valid = 1'b1; cmd_a = 32'd77; cmd_b = 32'd7; cmd_op = 2'd1;
        step();
        cmd_valid = 1'b0;
        step();
        checks++; if (issue_fire !== 1'b1 || a !== 32'd77 || in_databits !== 4'd1) begin errors++; $display("FAIL rmid_first got fire=%0b a=%0d tag=%0d exp 1 77 1", issue_fire, a, in_databits); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_streaming();
        test_stall_mid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
